// File: rtl/eth_mii_tx.sv
// eth_mii_tx: MII (4-bit) Ethernet frame transmitter.
// Reads len bytes from a byte-wide registered TX RAM and sends preamble, SFD, payload,
// zero pad up to MIN_LEN, optional FCS, then the inter-frame gap. One nibble per clk.
//
// Optional feature macro: ETH_TX_FCS_EN
//   defined   -> CRC-32 is computed over payload+pad and appended as a 4-byte FCS.
//   undefined -> no CRC logic; the frame ends after the last data/pad nibble.
//
// Ports:
//   clk          MII TX_CLK
//   rst_n        asynchronous active-low reset
//   start_i      1-cycle send request, honoured only when idle
//   len_i        frame byte count, latched on an accepted start
//   busy_o       high from accepted start to the end of the IFG
//   done_o       1-cycle pulse on the last IFG cycle
//   err_o        1-cycle pulse when a start is rejected (len 0 or > MAX_LEN)
//   buf_addr_o   TX RAM read address
//   buf_rdata_i  TX RAM read data, valid one clk after buf_addr_o
//   mii_txd_o    transmit nibble, low nibble of each byte first
//   mii_tx_en_o  transmit enable
//   mii_tx_er_o  transmit error, always 0
module eth_mii_tx #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1514,
  parameter int unsigned IFG_NIB = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [15:0]       len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] buf_addr_o,
  input  logic [7:0]        buf_rdata_i,
  output logic [3:0]        mii_txd_o,
  output logic              mii_tx_en_o,
  output logic              mii_tx_er_o
);

  localparam logic [15:0] MinLen  = 16'(MIN_LEN);
  localparam logic [15:0] MaxLen  = 16'(MAX_LEN);
  localparam logic [15:0] IfgLast = 16'(IFG_NIB - 1);
  localparam logic [15:0] IfgDone = 16'(IFG_NIB - 2);

  typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StFcs, StIfg} state_e;

  state_e            state_q;
  logic [15:0]       cnt_q;       // PRE / FCS / IFG cycle counter
  logic [15:0]       len_q;
  logic [15:0]       byte_cnt_q;  // bytes (payload or pad) started so far
  logic [7:0]        byte_q;      // byte being sent; holds 0 while padding
  logic              hi_q;        // high nibble of byte_q is on the wire
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        txd_q;
  logic              tx_en_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc_q;

  // Reflected CRC-32, one nibble, LSB first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      byte_q     <= '0;
      hi_q       <= 1'b0;
      addr_q     <= '0;
      txd_q      <= '0;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef ETH_TX_FCS_EN
      crc_q      <= '1;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
`ifdef ETH_TX_FCS_EN
          crc_q <= '1;
`endif
          if (start_i) begin
            if (len_i == 16'd0 || len_i > MaxLen) begin
              err_q <= 1'b1;
            end else begin
              len_q      <= len_i;
              addr_q     <= '0;
              byte_cnt_q <= '0;
              busy_q     <= 1'b1;
              tx_en_q    <= 1'b1;
              txd_q      <= 4'h5;
              cnt_q      <= '0;
              state_q    <= StPre;
            end
          end
        end
        StPre: begin
          if (cnt_q == 16'd14) begin
            txd_q   <= 4'hD;
            state_q <= StSfd;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        // Byte fetch happens on the low-nibble edge; the address then advances during the
        // high-nibble cycle so the registered RAM has the next byte ready two edges later.
        StSfd, StData: begin
          if (state_q == StData && !hi_q) begin
            txd_q <= byte_q[7:4];
            hi_q  <= 1'b1;
`ifdef ETH_TX_FCS_EN
            crc_q <= crc_nib(crc_q, byte_q[7:4]);
`endif
          end else if (byte_cnt_q < len_q) begin
            byte_q     <= buf_rdata_i;
            txd_q      <= buf_rdata_i[3:0];
            addr_q     <= addr_q + ADDR_W'(1);
            byte_cnt_q <= byte_cnt_q + 16'd1;
            hi_q       <= 1'b0;
            state_q    <= StData;
`ifdef ETH_TX_FCS_EN
            crc_q      <= crc_nib(crc_q, buf_rdata_i[3:0]);
`endif
          end else if (byte_cnt_q < MinLen) begin
            byte_q     <= '0;
            txd_q      <= '0;
            byte_cnt_q <= byte_cnt_q + 16'd1;
            hi_q       <= 1'b0;
`ifdef ETH_TX_FCS_EN
            crc_q      <= crc_nib(crc_q, 4'h0);
`endif
          end else begin
            cnt_q <= '0;
`ifdef ETH_TX_FCS_EN
            txd_q   <= ~crc_q[3:0];
            crc_q   <= {4'h0, crc_q[31:4]};
            state_q <= StFcs;
`else
            txd_q   <= '0;
            tx_en_q <= 1'b0;
            state_q <= StIfg;
`endif
          end
        end
`ifdef ETH_TX_FCS_EN
        StFcs: begin
          if (cnt_q == 16'd7) begin
            cnt_q   <= '0;
            txd_q   <= '0;
            tx_en_q <= 1'b0;
            state_q <= StIfg;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            txd_q <= ~crc_q[3:0];
            crc_q <= {4'h0, crc_q[31:4]};
          end
        end
`endif
        StIfg: begin
          cnt_q  <= cnt_q + 16'd1;
          done_q <= (cnt_q == IfgDone);
          if (cnt_q == IfgLast) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign buf_addr_o  = addr_q;
  assign mii_txd_o   = txd_q;
  assign mii_tx_en_o = tx_en_q;
  assign mii_tx_er_o = 1'b0;

endmodule
